// File: rtl/nibble_entry_ctrl.sv
// rtl/nibble_entry_ctrl.sv - push-button entry of an N-bit word, released over valid/ready
module nibble_entry_ctrl #(
    parameter int N            = 4,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int TIMEOUT_CYC  = 500000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   zeroes,
    input  logic                   ones,
    input  logic                   commit,
    input  logic                   out_ready,
    output logic [N-1:0]           out_data,
    output logic                   out_valid,
    output logic [N-1:0]           partial,
    output logic [$clog2(N+1)-1:0] bit_count,
    output logic                   err,
    output logic                   timeout
);
    localparam int BCW = $clog2(N+1);
    localparam int LKW = $clog2(DEBOUNCE_CYC+1);
    localparam int TMW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FULL, S_SEND} state_t;

    state_t         state_q, state_d;
    logic [2:0]     sync1_q, sync1_d;
    logic [2:0]     sync2_q, sync2_d;
    logic [2:0]     prev_q, prev_d;
    logic [N-1:0]   partial_q, partial_d;
    logic [BCW-1:0] bit_count_q, bit_count_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           err_q, err_d;
    logic           timeout_q, timeout_d;
    logic [LKW-1:0] lock_q, lock_d;
    logic [TMW-1:0] tmo_q, tmo_d;

    logic [2:0] btn_rise;
    logic       ev_any, multi, bit_ev, cmt_ev, bit_val, accepted;

    // bit order {commit, ones, zeroes}
    assign sync1_d  = {commit, ones, zeroes};
    assign sync2_d  = sync1_q;
    assign prev_d   = sync2_q;
    assign btn_rise = sync2_q & ~prev_q;

    assign ev_any  = (lock_q == '0) && (btn_rise != 3'b000);
    assign multi   = ev_any && ((btn_rise[0] & btn_rise[1]) | (btn_rise[0] & btn_rise[2]) |
                                (btn_rise[1] & btn_rise[2]));
    assign bit_ev  = ev_any && !multi && (btn_rise[0] | btn_rise[1]);
    assign cmt_ev  = ev_any && !multi && btn_rise[2];
    assign bit_val = btn_rise[1];

    always_comb begin
        state_d     = state_q;
        partial_d   = partial_q;
        bit_count_d = bit_count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = multi;
        timeout_d   = 1'b0;
        lock_d      = (lock_q != '0) ? lock_q - LKW'(1) : '0;
        tmo_d       = '0;
        accepted    = 1'b0;

        if (ev_any) begin
            lock_d = LKW'(DEBOUNCE_CYC);
        end

        case (state_q)
            S_IDLE: begin
                if (bit_ev) begin
                    partial_d   = {partial_q[N-2:0], bit_val};
                    bit_count_d = BCW'(1);
                    state_d     = S_COLLECT;
                    accepted    = 1'b1;
                end
                if (cmt_ev) err_d = 1'b1;
            end
            S_COLLECT: begin
                if (bit_ev) begin
                    partial_d   = {partial_q[N-2:0], bit_val};
                    bit_count_d = bit_count_q + BCW'(1);
                    accepted    = 1'b1;
                    if (bit_count_q == BCW'(N-1)) state_d = S_FULL;
                end
                if (cmt_ev) err_d = 1'b1;
            end
            S_FULL: begin
                if (bit_ev) err_d = 1'b1;
                if (cmt_ev) begin
                    out_data_d  = partial_q;
                    out_valid_d = 1'b1;
                    partial_d   = '0;
                    bit_count_d = '0;
                    state_d     = S_SEND;
                    accepted    = 1'b1;
                end
            end
            S_SEND: begin
                if (bit_ev || cmt_ev) err_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Idle timer only matters while a partial word is held; an accepted event beats expiry
        if ((state_q == S_COLLECT) || (state_q == S_FULL)) begin
            if (accepted) begin
                tmo_d = '0;
            end else if (tmo_q == TMW'(TIMEOUT_CYC-1)) begin
                partial_d   = '0;
                bit_count_d = '0;
                timeout_d   = 1'b1;
                state_d     = S_IDLE;
            end else begin
                tmo_d = tmo_q + TMW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            partial_q   <= '0;
            bit_count_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            lock_q      <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            partial_q   <= partial_d;
            bit_count_q <= bit_count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            lock_q      <= lock_d;
            tmo_q       <= tmo_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign partial   = partial_q;
    assign bit_count = bit_count_q;
    assign err       = err_q;
    assign timeout   = timeout_q;

endmodule
